// File: rtl/result_stream_checker.sv
// Hardware checker for a core's result stream: scores each cycle against a loadable
// table of expected (valid, data) pairs and reports pass/fail counts, first mismatch, timeout and done.
module result_stream_checker #(
  parameter int DATA_W      = 32,
  parameter int NUM_VEC     = 8,
  parameter int START_DELAY = 7,
  parameter int STOP_DRAIN  = 3,
  parameter int TIMEOUT     = 1024,
  parameter int IDX_W       = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1,
  parameter int CNT_W       = $clog2(NUM_VEC + 1)
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              exp_wr_en,
  input  logic [IDX_W-1:0]  exp_wr_addr,
  input  logic [DATA_W-1:0] exp_wr_data,
  input  logic              exp_wr_valid,
  input  logic              arm_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic              result_valid_i,
  input  logic              stop_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o,
  output logic [CNT_W-1:0]  pass_cnt_o,
  output logic [CNT_W-1:0]  fail_cnt_o,
  output logic              first_fail_vld_o,
  output logic [IDX_W-1:0]  first_fail_idx_o,
  output logic [DATA_W-1:0] first_fail_data_o
);

  localparam int DLY_W = (START_DELAY > 0) ? $clog2(START_DELAY + 1) : 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            state;
  logic [DATA_W-1:0]     exp_data [NUM_VEC];
  logic [NUM_VEC-1:0]    exp_valid;
  logic [IDX_W-1:0]      idx;
  logic [DLY_W-1:0]      delay_cnt;
  logic [TMO_W-1:0]      drain_cnt;
  logic [STOP_DRAIN-1:0] stop_shr;
  logic [STOP_DRAIN-1:0] shr_next;
  logic                  stop_tail;
  logic                  exp_v;
  logic                  point;

  // Bit 0 holds the most recently sampled stop_i; the top bit is the drained tail.
  if (STOP_DRAIN > 1) begin : g_shr
    assign shr_next = {stop_shr[STOP_DRAIN-2:0], stop_i};
  end else begin : g_shr1
    assign shr_next = stop_i;
  end
  assign stop_tail = stop_shr[STOP_DRAIN-1];

  // Table is deliberately left out of reset so a reset does not force a reload.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && exp_wr_en && 32'(exp_wr_addr) < NUM_VEC) begin
      exp_data[exp_wr_addr]  <= exp_wr_data;
      exp_valid[exp_wr_addr] <= exp_wr_valid;
    end
  end

  always_comb begin
    exp_v = exp_valid[idx];
    point = (result_valid_i == exp_v) && (!exp_v || result_i == exp_data[idx]);
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state             <= S_IDLE;
      stop_shr          <= '0;
      idx               <= '0;
      delay_cnt         <= '0;
      drain_cnt         <= '0;
      pass_cnt_o        <= '0;
      fail_cnt_o        <= '0;
      first_fail_vld_o  <= 1'b0;
      first_fail_idx_o  <= '0;
      first_fail_data_o <= '0;
      timeout_o         <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (arm_i) begin
            stop_shr          <= '0;
            idx               <= '0;
            drain_cnt         <= '0;
            pass_cnt_o        <= '0;
            fail_cnt_o        <= '0;
            first_fail_vld_o  <= 1'b0;
            first_fail_idx_o  <= '0;
            first_fail_data_o <= '0;
            timeout_o         <= 1'b0;
            delay_cnt         <= DLY_W'(START_DELAY);
            state             <= (START_DELAY == 0) ? S_CHECK : S_WAIT;
          end
        end
        default: begin
          stop_shr <= shr_next;
          case (state)
            S_WAIT: begin
              delay_cnt <= delay_cnt - 1'b1;
              if (delay_cnt == DLY_W'(1)) state <= S_CHECK;
            end
            S_CHECK: begin
              if (!stop_shr[0]) begin
                if (point) begin
                  pass_cnt_o <= pass_cnt_o + 1'b1;
                end else begin
                  fail_cnt_o <= fail_cnt_o + 1'b1;
                  if (!first_fail_vld_o) begin
                    first_fail_vld_o  <= 1'b1;
                    first_fail_idx_o  <= idx;
                    first_fail_data_o <= result_i;
                  end
                end
                if (idx == IDX_W'(NUM_VEC - 1)) state <= S_DRAIN;
                else                             idx   <= idx + 1'b1;
              end
            end
            S_DRAIN: begin
              drain_cnt <= drain_cnt + 1'b1;
              if (!stop_tail && drain_cnt == TMO_W'(TIMEOUT - 1)) begin
                timeout_o <= 1'b1;
                state     <= S_DONE;
              end
            end
            default: state <= S_IDLE;
          endcase
          // Stop tail overrides any other transition; a sample taken on this edge still counts.
          if (stop_tail) state <= S_DONE;
        end
      endcase
    end
  end

  assign busy_o = (state == S_WAIT) || (state == S_CHECK) || (state == S_DRAIN);
  assign done_o = (state == S_DONE);
  assign pass_o = done_o && (pass_cnt_o == CNT_W'(NUM_VEC)) && !timeout_o;

endmodule

// File: tb/tb_result_stream_checker.sv
// Directed bench for result_stream_checker: fixed vector table, hand-computed expectations.
module tb_result_stream_checker;

  localparam int DATA_W      = 32;
  localparam int NUM_VEC     = 8;
  localparam int START_DELAY = 7;
  localparam int STOP_DRAIN  = 3;
  localparam int TIMEOUT     = 16;
  localparam int IDX_W       = 3;
  localparam int CNT_W       = 4;

  logic              clk = 1'b0;
  logic              n_reset = 1'b0;
  logic              exp_wr_en = 1'b0;
  logic [IDX_W-1:0]  exp_wr_addr = '0;
  logic [DATA_W-1:0] exp_wr_data = '0;
  logic              exp_wr_valid = 1'b0;
  logic              arm_i = 1'b0;
  logic [DATA_W-1:0] result_i = '0;
  logic              result_valid_i = 1'b0;
  logic              stop_i = 1'b0;
  logic              busy_o, done_o, pass_o, timeout_o;
  logic [CNT_W-1:0]  pass_cnt_o, fail_cnt_o;
  logic              first_fail_vld_o;
  logic [IDX_W-1:0]  first_fail_idx_o;
  logic [DATA_W-1:0] first_fail_data_o;

  result_stream_checker #(
    .DATA_W(DATA_W), .NUM_VEC(NUM_VEC), .START_DELAY(START_DELAY),
    .STOP_DRAIN(STOP_DRAIN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .n_reset(n_reset),
    .exp_wr_en(exp_wr_en), .exp_wr_addr(exp_wr_addr),
    .exp_wr_data(exp_wr_data), .exp_wr_valid(exp_wr_valid),
    .arm_i(arm_i), .result_i(result_i), .result_valid_i(result_valid_i), .stop_i(stop_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
    .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o),
    .first_fail_vld_o(first_fail_vld_o), .first_fail_idx_o(first_fail_idx_o),
    .first_fail_data_o(first_fail_data_o)
  );

  always #5 clk = ~clk;

  logic [31:0] tbl_data [8] = '{32'h00000008, 32'hFFFFFFFE, 32'h00000008, 32'h00000000,
                                32'h00000003, 32'hFFFFFFFF, 32'h00000007, 32'h00000000};
  logic        tbl_valid [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [31:0] drv_data [8];
  logic        drv_valid [8];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_vec(input int addr, input logic [31:0] data, input logic vld);
    exp_wr_en = 1'b1; exp_wr_addr = IDX_W'(addr); exp_wr_data = data; exp_wr_valid = vld;
    tick;
    exp_wr_en = 1'b0;
  endtask

  task automatic restore_drv;
    for (int i = 0; i < 8; i++) begin
      drv_data[i]  = tbl_data[i];
      drv_valid[i] = tbl_valid[i];
    end
  endtask

  // Arm, sit out the start delay, then present n_vec vectors; stop_i rises with vector stop_k.
  task automatic do_run(input int n_vec, input int stop_k);
    arm_i = 1'b1;
    tick;
    arm_i = 1'b0;
    exp_wr_en = 1'b0;
    check("busy_after_arm", 32'(busy_o), 32'd1);
    repeat (START_DELAY) tick;
    for (int k = 0; k < n_vec; k++) begin
      result_i       = drv_data[k];
      result_valid_i = drv_valid[k];
      if (k == stop_k) stop_i = 1'b1;
      tick;
    end
    result_i       = '0;
    result_valid_i = 1'b0;
  endtask

  task automatic finish_with_stop(input string tag);
    stop_i = 1'b1;
    repeat (STOP_DRAIN) tick;
    check({tag, "_done_early"}, 32'(done_o), 32'd0);
    tick;
    check({tag, "_done_on_time"}, 32'(done_o), 32'd1);
    stop_i = 1'b0;
  endtask

  initial begin
    restore_drv();
    tick; tick;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_pass", 32'(pass_o), 32'd0);
    check("rst_timeout", 32'(timeout_o), 32'd0);
    check("rst_pass_cnt", 32'(pass_cnt_o), 32'd0);
    check("rst_fail_cnt", 32'(fail_cnt_o), 32'd0);
    check("rst_ff_vld", 32'(first_fail_vld_o), 32'd0);
    n_reset = 1'b1;
    tick;

    for (int i = 0; i < 8; i++) write_vec(i, tbl_data[i], tbl_valid[i]);

    // Matching stream
    do_run(8, -1);
    check("t1_pass_cnt_drain", 32'(pass_cnt_o), 32'd8);
    check("t1_busy_drain", 32'(busy_o), 32'd1);
    finish_with_stop("t1");
    check("t1_pass_cnt", 32'(pass_cnt_o), 32'd8);
    check("t1_fail_cnt", 32'(fail_cnt_o), 32'd0);
    check("t1_pass", 32'(pass_o), 32'd1);
    check("t1_timeout", 32'(timeout_o), 32'd0);
    check("t1_ff_vld", 32'(first_fail_vld_o), 32'd0);
    check("t1_busy", 32'(busy_o), 32'd0);
    tick;
    check("t1_hold_done", 32'(done_o), 32'd1);

    // Vector 4 corrupted, re-armed from DONE
    restore_drv();
    drv_data[4] = 32'h00000004;
    do_run(8, -1);
    finish_with_stop("t2");
    check("t2_pass_cnt", 32'(pass_cnt_o), 32'd7);
    check("t2_fail_cnt", 32'(fail_cnt_o), 32'd1);
    check("t2_ff_vld", 32'(first_fail_vld_o), 32'd1);
    check("t2_ff_idx", 32'(first_fail_idx_o), 32'd4);
    check("t2_ff_data", first_fail_data_o, 32'h00000004);
    check("t2_pass", 32'(pass_o), 32'd0);

    // Expected-invalid slot carries garbage data
    restore_drv();
    drv_data[3] = 32'hDEADBEEF;
    do_run(8, -1);
    finish_with_stop("t3");
    check("t3_pass_cnt", 32'(pass_cnt_o), 32'd8);
    check("t3_fail_cnt", 32'(fail_cnt_o), 32'd0);
    check("t3_ff_vld", 32'(first_fail_vld_o), 32'd0);
    check("t3_pass", 32'(pass_o), 32'd1);

    // Stop raised while idx=5 and held
    restore_drv();
    do_run(8, 5);
    check("t4_pass_cnt_frozen", 32'(pass_cnt_o), 32'd6);
    check("t4_done_early", 32'(done_o), 32'd0);
    tick;
    stop_i = 1'b0;
    check("t4_done", 32'(done_o), 32'd1);
    check("t4_pass_cnt", 32'(pass_cnt_o), 32'd6);
    check("t4_fail_cnt", 32'(fail_cnt_o), 32'd0);
    check("t4_pass", 32'(pass_o), 32'd0);
    check("t4_timeout", 32'(timeout_o), 32'd0);

    // No stop: timeout after TIMEOUT cycles in DRAIN
    restore_drv();
    do_run(8, -1);
    repeat (TIMEOUT - 1) tick;
    check("t5_done_early", 32'(done_o), 32'd0);
    check("t5_timeout_early", 32'(timeout_o), 32'd0);
    tick;
    check("t5_done", 32'(done_o), 32'd1);
    check("t5_timeout", 32'(timeout_o), 32'd1);
    check("t5_pass_cnt", 32'(pass_cnt_o), 32'd8);
    check("t5_pass", 32'(pass_o), 32'd0);

    // Table write while in DONE must be ignored
    write_vec(2, 32'h00000BAD, 1'b1);

    // Reset mid-CHECK at idx 3 after one mismatch
    restore_drv();
    drv_data[1] = 32'h00000001;
    do_run(3, -1);
    check("t6_pre_fail_cnt", 32'(fail_cnt_o), 32'd1);
    check("t6_pre_ff_idx", 32'(first_fail_idx_o), 32'd1);
    n_reset = 1'b0;
    tick;
    check("t6_rst_busy", 32'(busy_o), 32'd0);
    check("t6_rst_done", 32'(done_o), 32'd0);
    check("t6_rst_pass_cnt", 32'(pass_cnt_o), 32'd0);
    check("t6_rst_fail_cnt", 32'(fail_cnt_o), 32'd0);
    check("t6_rst_ff_vld", 32'(first_fail_vld_o), 32'd0);
    check("t6_rst_ff_data", first_fail_data_o, 32'h0);
    n_reset = 1'b1;
    tick;

    // Re-arm in IDLE with a same-edge write to entry 0
    restore_drv();
    drv_data[0]  = 32'h12345678;
    exp_wr_en    = 1'b1;
    exp_wr_addr  = '0;
    exp_wr_data  = 32'h12345678;
    exp_wr_valid = 1'b1;
    do_run(8, -1);
    finish_with_stop("t7");
    check("t7_pass_cnt", 32'(pass_cnt_o), 32'd8);
    check("t7_fail_cnt", 32'(fail_cnt_o), 32'd0);
    check("t7_pass", 32'(pass_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
